dds_pulse_sequencer: RTL and testbench
======================================

// Module: dds_pulse_sequencer
// PURPOSE
// Sequences the DDS modulator datapath for pulsed/continuous RADAR operation. Counts the PRI in
// microsecond ticks, gates the transmit pulse, and drives the DDS IP config channel (PINC + phase
// OFFSET) per mode: unmodulated, linear frequency ramp (chirp), or Barker BPSK phase coding.
// Sits between the AXI-Lite config register bank and the DDS Compiler s_axis_config port.
// PARAMETERS
// FCLK_MHZ             125  clock cycles per microsecond tick
// PERIOD_COUNTER_BITS  15   width of period/pulse-width fields (us)
// PINC_BITS            30   DDS phase increment/offset width
// PHASE_OFFSET_180     536870911  OFFSET value for 180 deg shift
// PORTS
// clk             in   1        system clock, FCLK_MHZ MHz
// rst             in   1        asynchronous reset, active-high
// enable          in   1        config_reg_0[ENABLE_BIT]; 0 forces IDLE
// mode            in   3        config_reg_1 state: b0=1 continuous, b1=1 modulated, b2=1 freq / 0 phase
// period_us       in   15       PRI in us; 0 = no pulses
// width_us        in   15       pulse width in us; clamped to period_us
// pinc_start      in   30       phase increment at pulse/ramp start
// pinc_step       in   30       per-cycle PINC increment (freq mod only)
// barker_sel      in   3        0..6 -> Barker 2,3,4,5,7,11,13; 7 -> 13
// chip_cycles     in   8        clock cycles per Barker chip; 0 treated as 1
// cfg_tdata       out  60       {OFFSET[29:0], PINC[29:0]} to DDS config channel
// cfg_tvalid      out  1        config word valid
// cfg_tready      in   1        DDS accepts config word
// pulse_active    out  1        transmit gate
// pulse_start     out  1        one-cycle strobe at start of each period's pulse
// BEHAVIOUR
// - Reset: FSM=IDLE, cfg_tdata=0, cfg_tvalid=0, pulse_active=0, pulse_start=0, all counters 0.
// - Tick prescaler counts 0..FCLK_MHZ-1; us_tick on terminal count. Runs only outside IDLE.
// - FSM IDLE -> ON when enable=1 and period_us!=0. ON -> OFF when us count reaches width_us
//   (only if width_us<period_us and mode b0=0). OFF/ON -> ON at period wrap (count=period_us-1 on tick).
//   Any state -> IDLE in the cycle after enable=0 or period_us=0; prescaler and counters cleared.
// - Continuous (mode b0=1): pulse_active stays 1; period wrap still restarts ramp/Barker.
// - All config inputs latched at period start (entry to ON); mid-period changes apply next period.
// - pulse_start=1 in the first ON cycle of each period, same cycle the start config word is presented.
// - No mod (b1=0): PINC=pinc_start, OFFSET=0 for whole pulse.
// - Freq mod (b1=1,b2=1): PINC=pinc_start+k*pinc_step, k = cycles since period start; mod 2^30 wrap.
// - Phase mod (b1=1,b2=0): Barker code MSB first, chip_cycles clocks per chip; chip bit 1 -> OFFSET=0,
//   bit 0 -> PHASE_OFFSET_180. After last chip OFFSET=0 until next period. PINC=pinc_start.
// - OFF state: PINC=0, OFFSET=0 word issued once on entry.
// - Config channel: new word registered when computed value differs from last issued; cfg_tvalid
//   held with stable tdata until cfg_tready. If a newer word arrives while pending, it replaces
//   the pending word (latest wins, tvalid stays high). Freq mod changes every cycle -> tvalid
//   stays high continuously.
// - Latency: config word appears 1 clk after the triggering counter event (registered output).
// TESTING
// - Reset mid-pulse (period 10, width 3) -> all outputs 0 same cycle; resumes pulse_start 1 clk after release+enable.
// - mode=000, period_us=10, width_us=2, pinc_start=0x100 -> pulse_active high 250 clks, low 1000; pulse_start every 1250 clks; one word {0,0x100}.
// - mode=010, barker_sel=4 (B7), chip_cycles=5 -> OFFSET sequence 0,0,0,180,180,0,180 each 5 clks, then 0.
// - mode=110, pinc_start=0x3FFFFFF0, step=0x10 -> PINC wraps to 0x00000000 at k=1, 0x10 at k=2.
// - width_us=20, period_us=10 -> pulse_active stays 1, pulse_start every 1250 clks.
// - cfg_tready=0 for 20 clks in phase mode -> tvalid held; only latest OFFSET accepted when ready rises.

Source files
------------

// File: rtl/dds_pulse_sequencer.sv
// dds_pulse_sequencer: PRI timing in microsecond ticks, transmit gating and
// generation of {OFFSET, PINC} config words for a DDS config channel.
// Modes: unmodulated, linear frequency ramp, or Barker BPSK phase coding.
module dds_pulse_sequencer #(
  parameter int FCLK_MHZ            = 125,
  parameter int PERIOD_COUNTER_BITS = 15,
  parameter int PINC_BITS           = 30,
  parameter logic [PINC_BITS-1:0] PHASE_OFFSET_180 = 30'd536870911
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [2:0]                     mode,
  input  logic [PERIOD_COUNTER_BITS-1:0] period_us,
  input  logic [PERIOD_COUNTER_BITS-1:0] width_us,
  input  logic [PINC_BITS-1:0]           pinc_start,
  input  logic [PINC_BITS-1:0]           pinc_step,
  input  logic [2:0]                     barker_sel,
  input  logic [7:0]                     chip_cycles,
  output logic [2*PINC_BITS-1:0]         cfg_tdata,
  output logic                           cfg_tvalid,
  input  logic                           cfg_tready,
  output logic                           pulse_active,
  output logic                           pulse_start
);

  localparam int PCB   = PERIOD_COUNTER_BITS;
  localparam int PSC_W = (FCLK_MHZ > 1) ? $clog2(FCLK_MHZ) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(FCLK_MHZ - 1);
  localparam logic [PCB-1:0]   ONE_US   = PCB'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_OFF = 2'd2} state_t;

  // Barker codes left-aligned in 13 bits, first chip in bit 12.
  function automatic logic [12:0] barker_code(input logic [2:0] sel);
    case (sel)
      3'd0:    barker_code = 13'b10_00000000000;
      3'd1:    barker_code = 13'b110_0000000000;
      3'd2:    barker_code = 13'b1101_000000000;
      3'd3:    barker_code = 13'b11101_00000000;
      3'd4:    barker_code = 13'b1110010_000000;
      3'd5:    barker_code = 13'b11100010010_00;
      default: barker_code = 13'b1111100110101;
    endcase
  endfunction

  function automatic logic [3:0] barker_len(input logic [2:0] sel);
    case (sel)
      3'd0:    barker_len = 4'd2;
      3'd1:    barker_len = 4'd3;
      3'd2:    barker_len = 4'd4;
      3'd3:    barker_len = 4'd5;
      3'd4:    barker_len = 4'd7;
      3'd5:    barker_len = 4'd11;
      default: barker_len = 4'd13;
    endcase
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [PSC_W-1:0]       r_presc;
  logic [PCB-1:0]         r_us;
  logic [2:0]             r_mode;
  logic [PCB-1:0]         r_period, r_width;
  logic [PINC_BITS-1:0]   r_pinc_start, r_pinc_step, r_ramp;
  logic [2:0]             r_barker_sel;
  logic [7:0]             r_chip_cycles, r_chip_cnt;
  logic [3:0]             r_chip_idx;
  logic [2*PINC_BITS-1:0] r_cfg_tdata;
  logic                   r_cfg_tvalid, r_pulse_active, r_pulse_start;

  logic                   w_tick, w_wrap, w_width_end, w_stop, w_start;
  logic [PINC_BITS-1:0]   w_ramp_nxt, w_pinc, w_off;
  logic [7:0]             w_cnt_nxt, w_chip_last;
  logic [3:0]             w_idx_nxt;
  logic [2:0]             w_sel_eff;
  logic [12:0]            w_code_sh;
  logic                   w_freq_mode, w_phase_mode, w_phase_flip;
  logic [2*PINC_BITS-1:0] w_word;

  assign w_tick      = (r_state != S_IDLE) && (r_presc == PSC_LAST);
  assign w_wrap      = w_tick && (r_us == r_period - ONE_US);
  // Pulse ends early only when it is shorter than the PRI and not continuous.
  assign w_width_end = w_tick && (r_us == r_width - ONE_US) && (r_width < r_period) && !r_mode[0];
  assign w_stop      = !enable || (period_us == {PCB{1'b0}});
  assign w_chip_last = (r_chip_cycles == 8'd0) ? 8'd0 : (r_chip_cycles - 8'd1);

  // Next-state logic; w_start marks the edge that begins a new period.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ON;
          w_start     = 1'b1;
        end
        S_ON: begin
          if (w_wrap) begin
            w_state_nxt = S_ON;
            w_start     = 1'b1;
          end else if (w_width_end) begin
            w_state_nxt = S_OFF;
          end else begin
            w_state_nxt = S_ON;
          end
        end
        S_OFF: begin
          if (w_wrap) begin
            w_state_nxt = S_ON;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_OFF;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the frequency ramp and Barker chip position.
  always_comb begin
    w_ramp_nxt = r_ramp;
    w_cnt_nxt  = r_chip_cnt;
    w_idx_nxt  = r_chip_idx;
    if (w_state_nxt == S_IDLE) begin
      w_ramp_nxt = {PINC_BITS{1'b0}};
      w_cnt_nxt  = 8'd0;
      w_idx_nxt  = 4'd0;
    end else if (w_start) begin
      w_ramp_nxt = pinc_start;
      w_cnt_nxt  = 8'd0;
      w_idx_nxt  = 4'd0;
    end else begin
      w_ramp_nxt = r_ramp + r_pinc_step;
      if (r_chip_idx < barker_len(r_barker_sel)) begin
        if (r_chip_cnt == w_chip_last) begin
          w_cnt_nxt = 8'd0;
          w_idx_nxt = r_chip_idx + 4'd1;
        end else begin
          w_cnt_nxt = r_chip_cnt + 8'd1;
        end
      end else begin
        w_cnt_nxt = r_chip_cnt;
      end
    end
  end

  // Config word for the next cycle; at a period start the live inputs are used
  // because they are being latched on that same edge.
  always_comb begin
    w_sel_eff    = w_start ? barker_sel : r_barker_sel;
    w_freq_mode  = w_start ? (mode[1] & mode[2])  : (r_mode[1] & r_mode[2]);
    w_phase_mode = w_start ? (mode[1] & ~mode[2]) : (r_mode[1] & ~r_mode[2]);
    w_code_sh    = barker_code(w_sel_eff) << w_idx_nxt;
    w_phase_flip = w_phase_mode && (w_idx_nxt < barker_len(w_sel_eff)) && !w_code_sh[12];
    w_off        = w_phase_flip ? PHASE_OFFSET_180 : {PINC_BITS{1'b0}};
    if (w_freq_mode) begin
      w_pinc = w_ramp_nxt;
    end else begin
      w_pinc = w_start ? pinc_start : r_pinc_start;
    end
    if (w_state_nxt == S_ON) begin
      w_word = {w_off, w_pinc};
    end else begin
      w_word = {(2*PINC_BITS){1'b0}};
    end
  end

  // State, prescaler, microsecond counter and modulation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_presc    <= {PSC_W{1'b0}};
      r_us       <= {PCB{1'b0}};
      r_ramp     <= {PINC_BITS{1'b0}};
      r_chip_cnt <= 8'd0;
      r_chip_idx <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ramp     <= w_ramp_nxt;
      r_chip_cnt <= w_cnt_nxt;
      r_chip_idx <= w_idx_nxt;
      if (r_state == S_IDLE || w_state_nxt == S_IDLE || w_tick) begin
        r_presc <= {PSC_W{1'b0}};
      end else begin
        r_presc <= r_presc + {{(PSC_W-1){1'b0}}, 1'b1};
      end
      if (r_state == S_IDLE || w_state_nxt == S_IDLE || w_wrap) begin
        r_us <= {PCB{1'b0}};
      end else if (w_tick) begin
        r_us <= r_us + ONE_US;
      end
    end
  end

  // Configuration snapshot taken at every period start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode        <= 3'd0;
      r_period      <= {PCB{1'b0}};
      r_width       <= {PCB{1'b0}};
      r_pinc_start  <= {PINC_BITS{1'b0}};
      r_pinc_step   <= {PINC_BITS{1'b0}};
      r_barker_sel  <= 3'd0;
      r_chip_cycles <= 8'd0;
    end else if (w_start) begin
      r_mode        <= mode;
      r_period      <= period_us;
      r_width       <= width_us;
      r_pinc_start  <= pinc_start;
      r_pinc_step   <= pinc_step;
      r_barker_sel  <= barker_sel;
      r_chip_cycles <= chip_cycles;
    end
  end

  // Output channel: a changed word replaces whatever is pending (latest wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_tdata    <= {(2*PINC_BITS){1'b0}};
      r_cfg_tvalid   <= 1'b0;
      r_pulse_active <= 1'b0;
      r_pulse_start  <= 1'b0;
    end else begin
      r_pulse_active <= (w_state_nxt == S_ON);
      r_pulse_start  <= w_start;
      if (w_word != r_cfg_tdata) begin
        r_cfg_tdata  <= w_word;
        r_cfg_tvalid <= 1'b1;
      end else if (r_cfg_tvalid && cfg_tready) begin
        r_cfg_tvalid <= 1'b0;
      end
    end
  end

  assign cfg_tdata    = r_cfg_tdata;
  assign cfg_tvalid   = r_cfg_tvalid;
  assign pulse_active = r_pulse_active;
  assign pulse_start  = r_pulse_start;

endmodule

// File: tb/tb_dds_pulse_sequencer.sv
// Self-checking bench for dds_pulse_sequencer: directed scenarios plus
// randomized configurations against a period-level behavioural model.
module tb_dds_pulse_sequencer;

  localparam int FCLK = 125;
  localparam logic [29:0] OFF180 = 30'd536870911;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [14:0] period_us = 15'd0, width_us = 15'd0;
  logic [29:0] pinc_start = 30'd0, pinc_step = 30'd0;
  logic [2:0]  barker_sel = 3'd0;
  logic [7:0]  chip_cycles = 8'd0;
  logic        cfg_tready = 1'b1;
  logic [59:0] cfg_tdata;
  logic        cfg_tvalid, pulse_active, pulse_start;

  int n_tests = 0;
  int n_fail  = 0;

  dds_pulse_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .period_us(period_us), .width_us(width_us),
    .pinc_start(pinc_start), .pinc_step(pinc_step),
    .barker_sel(barker_sel), .chip_cycles(chip_cycles),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .pulse_active(pulse_active), .pulse_start(pulse_start)
  );

  always #4 clk = ~clk;

  // Barker codes, right-aligned, with their lengths (index = barker_sel).
  int BLEN[8]  = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd11, 32'd13, 32'd13};
  int BCODE[8] = '{32'b10, 32'b110, 32'b1101, 32'b11101, 32'b1110010,
                   32'b11100010010, 32'b1111100110101, 32'b1111100110101};

  // Reference model: time since period start plus the latched configuration.
  bit          m_idle = 1'b1;
  int          m_t = 0;
  logic [2:0]  m_mode = 3'd0;
  int          m_period = 0, m_width = 0, m_sel = 0, m_chip = 0;
  longint      m_start = 0, m_step = 0;
  bit          m_active = 1'b0, m_pstart = 1'b0, m_tvalid = 1'b0;
  logic [59:0] m_tdata = 60'd0;
  logic [59:0] m_acc[$];
  logic [59:0] d_acc[$];

  // Words actually accepted by the downstream side.
  always @(posedge clk) begin
    if (!rst && cfg_tvalid && cfg_tready) d_acc.push_back(cfg_tdata);
  end

  function automatic logic [59:0] model_word();
    int cyc, idx;
    longint p;
    logic [29:0] off;
    if (!m_active) return 60'd0;
    cyc = (m_chip == 0) ? 1 : m_chip;
    idx = m_t / cyc;
    off = 30'd0;
    if (m_mode[1] && !m_mode[2] && idx < BLEN[m_sel])
      if (((BCODE[m_sel] >> (BLEN[m_sel] - 1 - idx)) & 1) == 0) off = OFF180;
    if (m_mode[1] && m_mode[2]) p = (m_start + longint'(m_t) * m_step) & 64'h3FFF_FFFF;
    else p = m_start;
    return {off, p[29:0]};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_t = 0; m_active = 1'b0; m_pstart = 1'b0;
    m_tdata = 60'd0; m_tvalid = 1'b0;
  endtask

  task automatic model_latch();
    m_mode = mode; m_period = int'(period_us); m_width = int'(width_us);
    m_start = longint'(pinc_start); m_step = longint'(pinc_step);
    m_sel = int'(barker_sel); m_chip = int'(chip_cycles);
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    logic [59:0] w;
    if (rst) begin model_reset(); return; end
    if (m_tvalid && cfg_tready) m_acc.push_back(m_tdata);
    if (!enable || period_us == 15'd0) begin
      m_idle = 1'b1; m_t = 0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_t = 0; model_latch();
    end else begin
      m_t++;
      if (m_t == m_period * FCLK) begin m_t = 0; model_latch(); end
    end
    m_active = !m_idle && (m_mode[0] || m_width >= m_period || m_t < m_width * FCLK);
    m_pstart = !m_idle && (m_t == 0);
    w = model_word();
    if (w != m_tdata) begin m_tdata = w; m_tvalid = 1'b1; end
    else if (m_tvalid && cfg_tready) m_tvalid = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle();
    enable = 1'b0; cfg_tready = 1'b1;
    repeat (4) tick();
    m_acc.delete(); d_acc.delete();
  endtask

  task automatic rand_cfg();
    mode        = 3'($urandom_range(0, 7));
    period_us   = 15'($urandom_range(1, 4));
    width_us    = 15'($urandom_range(1, 5));
    pinc_start  = 30'($urandom);
    pinc_step   = 30'($urandom);
    barker_sel  = 3'($urandom_range(0, 7));
    chip_cycles = 8'($urandom_range(0, 4));
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_tests++; if (pulse_active !== 1'b0) begin n_fail++; $display("FAIL reset.active got=%0b exp=0", pulse_active); end
    n_tests++; if (pulse_start !== 1'b0) begin n_fail++; $display("FAIL reset.start got=%0b exp=0", pulse_start); end
    n_tests++; if (cfg_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset.tvalid got=%0b exp=0", cfg_tvalid); end
    n_tests++; if (cfg_tdata !== 60'd0) begin n_fail++; $display("FAIL reset.tdata got=%h exp=0", cfg_tdata); end
    mode = 3'd0; period_us = 15'd10; width_us = 15'd3; pinc_start = 30'h55;
    rst = 1'b0; enable = 1'b1;
    repeat (300) tick();
    n_tests++; if (pulse_active !== 1'b1) begin n_fail++; $display("FAIL reset.midpulse got=%0b exp=1", pulse_active); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({pulse_active, pulse_start, cfg_tvalid} !== 3'b000 || cfg_tdata !== 60'd0) begin
      n_fail++; $display("FAIL reset.async got=%0b%0b%0b/%h exp=000/0", pulse_active, pulse_start, cfg_tvalid, cfg_tdata);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++; if (pulse_start !== 1'b1 || pulse_active !== 1'b1) begin
      n_fail++; $display("FAIL reset.resume got=%0b%0b exp=11", pulse_start, pulse_active);
    end
    n_tests++; if (cfg_tdata !== {30'd0, 30'h55} || cfg_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL reset.resume_word got=%h/%0b exp=%h/1", cfg_tdata, cfg_tvalid, {30'd0, 30'h55});
    end
  endtask

  task automatic test_nomod();
    int hi, lo, bad;
    int starts[$];
    go_idle();
    mode = 3'd0; period_us = 15'd10; width_us = 15'd2; pinc_start = 30'h100;
    pinc_step = 30'($urandom); enable = 1'b1;
    hi = 0; lo = 0; bad = 0;
    for (int i = 0; i < 2600; i++) begin
      tick();
      if (i < 1250) begin if (pulse_active) hi++; else lo++; end
      if (pulse_start) starts.push_back(i);
      if (cfg_tdata !== m_tdata) bad++;
    end
    n_tests++; if (hi != 250) begin n_fail++; $display("FAIL nomod.high got=%0d exp=250", hi); end
    n_tests++; if (lo != 1000) begin n_fail++; $display("FAIL nomod.low got=%0d exp=1000", lo); end
    n_tests++; if (starts.size() != 3 || starts[0] != 0 || starts[1] != 1250 || starts[2] != 2500) begin
      n_fail++; $display("FAIL nomod.starts got_count=%0d exp=3 at 0,1250,2500", starts.size());
    end
    n_tests++; if (d_acc.size() != 5 || d_acc[0] !== {30'd0, 30'h100} || d_acc[1] !== 60'd0) begin
      n_fail++; $display("FAIL nomod.words got_count=%0d exp=5 starting {0,100},0", d_acc.size());
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL nomod.tdata got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_barker();
    int bad;
    logic [6:0] b7;
    logic [29:0] exp_off;
    go_idle();
    b7 = 7'b1110010;
    mode = 3'b010; barker_sel = 3'd4; chip_cycles = 8'd5;
    period_us = 15'd2; width_us = 15'd2; pinc_start = 30'h1234; enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      exp_off = (i / 5 < 7 && b7[6 - i / 5] == 1'b0) ? OFF180 : 30'd0;
      n_tests++; if (cfg_tdata !== {exp_off, 30'h1234}) begin
        n_fail++; $display("FAIL barker.word cyc=%0d got=%h exp=%h", i, cfg_tdata, {exp_off, 30'h1234});
      end
      if (cfg_tdata !== m_tdata || cfg_tvalid !== m_tvalid) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL barker.model got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_freq_wrap();
    int lowv;
    go_idle();
    mode = 3'b110; pinc_start = 30'h3FFFFFF0; pinc_step = 30'h10;
    period_us = 15'd3; width_us = 15'd3; enable = 1'b1;
    tick();
    n_tests++; if (cfg_tdata[29:0] !== 30'h3FFFFFF0 || pulse_start !== 1'b1) begin
      n_fail++; $display("FAIL freq.k0 got=%h/%0b exp=3ffffff0/1", cfg_tdata[29:0], pulse_start);
    end
    tick();
    n_tests++; if (cfg_tdata[29:0] !== 30'h0) begin n_fail++; $display("FAIL freq.k1 got=%h exp=0", cfg_tdata[29:0]); end
    tick();
    n_tests++; if (cfg_tdata[29:0] !== 30'h10) begin n_fail++; $display("FAIL freq.k2 got=%h exp=10", cfg_tdata[29:0]); end
    lowv = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cfg_tvalid !== 1'b1 || cfg_tdata !== m_tdata) lowv++;
    end
    n_tests++; if (lowv != 0) begin n_fail++; $display("FAIL freq.stream got=%0d bad cycles exp=0", lowv); end
  endtask

  task automatic test_clamp();
    int lo;
    int starts[$];
    go_idle();
    mode = 3'd0; period_us = 15'd10; width_us = 15'd20; pinc_start = 30'h777; enable = 1'b1;
    lo = 0;
    for (int i = 0; i < 2600; i++) begin
      tick();
      if (!pulse_active) lo++;
      if (pulse_start) starts.push_back(i);
    end
    n_tests++; if (lo != 0) begin n_fail++; $display("FAIL clamp.active got=%0d low cycles exp=0", lo); end
    n_tests++; if (starts.size() != 3 || starts[1] - starts[0] != 1250 || starts[2] - starts[1] != 1250) begin
      n_fail++; $display("FAIL clamp.starts got_count=%0d exp=3 spaced 1250", starts.size());
    end
  endtask

  task automatic test_stall();
    int lowv;
    logic [29:0] st;
    go_idle();
    st = 30'($urandom_range(1, 32'h0FFF_FFFF));
    mode = 3'b010; barker_sel = 3'd6; chip_cycles = 8'd1;
    period_us = 15'd1; width_us = 15'd1; pinc_start = st;
    cfg_tready = 1'b0; enable = 1'b1;
    lowv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_tvalid !== 1'b1) lowv++;
    end
    n_tests++; if (lowv != 0 || d_acc.size() != 0) begin
      n_fail++; $display("FAIL stall.hold got=%0d low/%0d accepted exp=0/0", lowv, d_acc.size());
    end
    cfg_tready = 1'b1;
    repeat (10) tick();
    n_tests++; if (d_acc.size() != 1 || d_acc[0] !== {30'd0, st}) begin
      n_fail++; $display("FAIL stall.latest got_count=%0d exp=1 word %h", d_acc.size(), {30'd0, st});
    end
  endtask

  task automatic test_random();
    int prints;
    prints = 0;
    for (int it = 0; it < 10; it++) begin
      go_idle();
      rand_cfg();
      enable = 1'b1;
      for (int i = 0; i < 700; i++) begin
        if (i == 300) rand_cfg();
        if (i == 500 && it % 3 == 0) enable = 1'b0;
        if (i == 503) enable = 1'b1;
        cfg_tready = ($urandom_range(0, 3) != 0);
        tick();
        n_tests++; if (pulse_active !== m_active || pulse_start !== m_pstart ||
                       cfg_tvalid !== m_tvalid || cfg_tdata !== m_tdata) begin
          n_fail++;
          if (prints < 20) begin
            prints++;
            $display("FAIL random it=%0d cyc=%0d got=%0b%0b%0b/%h exp=%0b%0b%0b/%h", it, i,
                     pulse_active, pulse_start, cfg_tvalid, cfg_tdata, m_active, m_pstart, m_tvalid, m_tdata);
          end
        end
      end
      n_tests++; if (d_acc != m_acc) begin
        n_fail++; $display("FAIL random.accepted it=%0d got_count=%0d exp_count=%0d", it, d_acc.size(), m_acc.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nomod();
    test_barker();
    test_freq_wrap();
    test_clamp();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
